// File: rtl/float13_pkg.sv
// Shared definitions for the 13-bit float multiplier: field widths, bias and
// the packed {sign, exp, frac} view of an operand.
package float13_pkg;

  localparam int EXP_W   = 4;
  localparam int MAN_W   = 8;
  localparam int BIAS    = 7;
  localparam int EXP_MAX = 15;
  localparam int FLT_W   = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } flt13_t;

  // Magnitudes (exp+frac) for flushed and saturated results.
  localparam logic [FLT_W-2:0] ZERO    = '0;
  localparam logic [FLT_W-2:0] SAT_MAG = '1;

endpackage

// File: rtl/top_ej1_fmul_if.sv
// Operand/result bundle of the float multiplier. Handshake: a pair is taken on
// every rising edge with i_valid=1 (no ready); o_valid marks o_mutiplicado.
interface fmul_if;
  import float13_pkg::*;

  logic             i_valid;
  logic [FLT_W-1:0] i_flotante_1;
  logic [FLT_W-1:0] i_flotante_2;
  logic [FLT_W-1:0] o_mutiplicado;
  logic             o_valid;

  modport master (output i_valid, i_flotante_1, i_flotante_2,
                  input  o_mutiplicado, o_valid);
  modport slave  (input  i_valid, i_flotante_1, i_flotante_2,
                  output o_mutiplicado, o_valid);
endinterface

// File: rtl/top_ej1_fmul_mantissa.sv
// Combinational 9x9 mantissa multiplier and normaliser.
// FMUL_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fmul_mantissa
  import float13_pkg::*;
(
  input  logic [MAN_W-1:0] frac_a,
  input  logic [MAN_W-1:0] frac_b,
  output logic [MAN_W-1:0] frac,
  output logic             norm,
  output logic             carry
);

  logic [2*MAN_W+1:0] prod;
  logic [MAN_W-1:0]   trunc;

  assign prod  = {1'b1, frac_a} * {1'b1, frac_b};
  assign norm  = prod[2*MAN_W+1];
  assign trunc = norm ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];

`ifdef FMUL_ROUND_NEAREST_EN
  logic guard;
  logic sticky;
  logic round_up;

  assign guard    = norm ? prod[MAN_W]     : prod[MAN_W-1];
  assign sticky   = norm ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
  assign round_up = guard & (sticky | trunc[0]);
  // A carry out of the fraction means the rounded mantissa is exactly 2.0.
  assign {carry, frac} = {1'b0, trunc} + {{MAN_W{1'b0}}, round_up};
`else
  logic unused_low;

  assign unused_low = ^prod[MAN_W-1:0];
  assign frac       = trunc;
  assign carry      = 1'b0;
`endif

endmodule

// File: rtl/top_ej1_fmul.sv
// Registered 13-bit float multiplier (1-cycle latency): sign, exponent,
// zero/underflow/saturation handling. Optional macro: FMUL_ROUND_NEAREST_EN.
module top_ej1_fmul
  import float13_pkg::*;
(
  input  logic   clock,
  input  logic   i_rst_n,
  fmul_if.slave  bus
);

  flt13_t            op_a;
  flt13_t            op_b;
  flt13_t            res_d;
  flt13_t            res_q;
  logic              valid_q;
  logic [MAN_W-1:0]  frac;
  logic              norm;
  logic              carry;
  logic              sign;
  logic [6:0]        exp_raw;
  logic signed [6:0] exp_e;

  assign op_a = bus.i_flotante_1;
  assign op_b = bus.i_flotante_2;

  fmul_mantissa u_mantissa (
    .frac_a (op_a.frac),
    .frac_b (op_b.frac),
    .frac   (frac),
    .norm   (norm),
    .carry  (carry)
  );

  assign sign    = op_a.sign ^ op_b.sign;
  assign exp_raw = {3'b000, op_a.exp} + {3'b000, op_b.exp}
                 + {6'b000000, norm} + {6'b000000, carry};
  assign exp_e   = $signed(exp_raw) - $signed(7'(BIAS));

  always_comb begin
    res_d = {sign, exp_e[EXP_W-1:0], frac};
    if (op_a.exp == '0 || op_b.exp == '0 || exp_e <= 7'sd0)
      res_d = {sign, ZERO};
    else if (exp_e > $signed(7'(EXP_MAX)))
      res_d = {sign, SAT_MAG};
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.i_valid;
      if (bus.i_valid)
        res_q <= res_d;
    end
  end

  assign bus.o_mutiplicado = res_q;
  assign bus.o_valid       = valid_q;

endmodule

// File: tb/tb_top_ej1_fmul.sv
// Bench for top_ej1_fmul: fixed vectors, specials, reset and random stream
// checked against an arithmetic reference model.
module tb_top_ej1_fmul;

  logic clock;
  logic i_rst_n;
  int   tests_run;
  int   tests_failed;
  logic [12:0] exp_q[$];
  logic [12:0] last_res;

  fmul_if bus ();

  top_ej1_fmul dut (
    .clock   (clock),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: exact integer product, leading-one search, then range checks.
  function automatic logic [12:0] ref_mul(input logic [12:0] a, input logic [12:0] b);
    int ea, eb, p, k, q, e;
    logic s;
    s  = a[12] ^ b[12];
    ea = int'(a[11:8]);
    eb = int'(b[11:8]);
    if (ea == 0 || eb == 0) return {s, 12'd0};
    p = (256 + int'(a[7:0])) * (256 + int'(b[7:0]));
    k = 16;
    while (p >= (1 << (k + 1))) k++;
    q = p >> (k - 8);
    e = ea + eb - 7 + (k - 16);
`ifdef FMUL_ROUND_NEAREST_EN
    begin
      int rem, half;
      rem  = p - (q << (k - 8));
      half = 1 << (k - 9);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 512) begin
        q = 256;
        e++;
      end
    end
`endif
    if (e <= 0) return {s, 12'd0};
    if (e >= 16) return {s, 12'hfff};
    return {s, 4'(e), 8'(q - 256)};
  endfunction

  task automatic drive(input logic v, input logic [12:0] a, input logic [12:0] b);
    bus.i_valid      = v;
    bus.i_flotante_1 = a;
    bus.i_flotante_2 = b;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (bus.o_mutiplicado !== 13'd0 || bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got o=%b v=%b, want o=0 v=0", bus.o_mutiplicado, bus.o_valid);
    end
    @(negedge clock);
    @(negedge clock);
    tests_run++;
    if (bus.o_mutiplicado !== 13'd0 || bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: got o=%b v=%b, want o=0 v=0", bus.o_mutiplicado, bus.o_valid);
    end
    i_rst_n = 1'b1;
  endtask

  // Single-shot vectors with an idle cycle after each.
  task automatic test_plan();
    logic [12:0] va[5];
    logic [12:0] vb[5];
    logic [12:0] vr[5];
    va = '{13'b1_0101_11000110, 13'b0_0011_11001101, 13'b0_1100_00011101,
           13'b1_0101_11000110, 13'b0_1100_00011101};
    vb = '{13'b0_1100_00011101, 13'b1_1011_00101011, 13'b0_0011_11001101,
           13'b1_1011_00101011, 13'b0_1100_00011101};
    vr = '{13'b1_1010_11111001, 13'b1_1000_00001101, 13'b0_1001_00000000,
           13'b0_1010_00001001, 13'b0_0000_00000000};
    vr[4] = ref_mul(va[4], vb[4]);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, va[i], vb[i]);
      @(negedge clock);
      drive(1'b0, 13'h1abc, 13'h0123);
      tests_run++;
      if (bus.o_valid !== 1'b1 || bus.o_mutiplicado !== ref_mul(va[i], vb[i])) begin
        tests_failed++;
        $display("FAIL plan_model[%0d]: got o=%b v=%b, want o=%b v=1", i, bus.o_mutiplicado, bus.o_valid, ref_mul(va[i], vb[i]));
      end
`ifndef FMUL_ROUND_NEAREST_EN
      tests_run++;
      if (bus.o_mutiplicado !== vr[i]) begin
        tests_failed++;
        $display("FAIL plan_const[%0d]: got %b, want %b", i, bus.o_mutiplicado, vr[i]);
      end
`endif
      last_res = bus.o_mutiplicado;
      @(negedge clock);
      tests_run++;
      if (bus.o_valid !== 1'b0 || bus.o_mutiplicado !== last_res) begin
        tests_failed++;
        $display("FAIL plan_idle[%0d]: got o=%b v=%b, want o=%b v=0", i, bus.o_mutiplicado, bus.o_valid, last_res);
      end
    end
  endtask

  // Original and swapped pairs on consecutive cycles; o_valid must stay high.
  task automatic test_back_to_back();
    logic [12:0] va[3];
    logic [12:0] vb[3];
    va = '{13'b1_0101_11000110, 13'b0_0011_11001101, 13'b0_1100_00011101};
    vb = '{13'b0_1100_00011101, 13'b1_1011_00101011, 13'b0_0011_11001101};
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1'b1, va[i/2], vb[i/2]);
      else            drive(1'b1, vb[i/2], va[i/2]);
      exp_q.push_back(ref_mul(va[i/2], vb[i/2]));
      @(negedge clock);
      tests_run++;
      if (bus.o_valid !== 1'b1 || bus.o_mutiplicado !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: got o=%b v=%b, want o=%b v=1", i, bus.o_mutiplicado, bus.o_valid, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    drive(1'b0, 13'd0, 13'd0);
    @(negedge clock);
  endtask

  task automatic test_special();
    logic [12:0] va[4];
    logic [12:0] vb[4];
    logic [12:0] vr[4];
    va = '{13'd0, 13'b0_0001_00000000, 13'b0_1111_00000000, 13'b1_0000_10101010};
    vb = '{13'b0_1100_00011101, 13'b0_0001_00000000, 13'b1_1111_00000000, 13'b0_1111_11111111};
    vr = '{13'b0_0000_00000000, 13'b0_0000_00000000, 13'b1_1111_11111111, 13'b1_0000_00000000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i]);
      @(negedge clock);
      tests_run++;
      if (bus.o_valid !== 1'b1 || bus.o_mutiplicado !== vr[i]) begin
        tests_failed++;
        $display("FAIL special[%0d]: got o=%b v=%b, want o=%b v=1", i, bus.o_mutiplicado, bus.o_valid, vr[i]);
      end
    end
    drive(1'b0, 13'd0, 13'd0);
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [12:0] a, b;
    logic        v;
    logic        prev_v;
    prev_v   = 1'b0;
    last_res = bus.o_mutiplicado;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      a = 13'($urandom_range(0, 8191));
      b = 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 7) == 0) a[11:8] = 4'($urandom_range(0, 1) * 15);
      drive(v, a, b);
      if (v) exp_q.push_back(ref_mul(a, b));
      prev_v = v;
      @(negedge clock);
      tests_run++;
      if (prev_v) begin
        last_res = exp_q.pop_front();
        if (bus.o_valid !== 1'b1 || bus.o_mutiplicado !== last_res) begin
          tests_failed++;
          $display("FAIL random[%0d]: a=%b b=%b got o=%b v=%b, want o=%b v=1", i, a, b, bus.o_mutiplicado, bus.o_valid, last_res);
        end
      end else if (bus.o_valid !== 1'b0 || bus.o_mutiplicado !== last_res) begin
        tests_failed++;
        $display("FAIL random_idle[%0d]: got o=%b v=%b, want o=%b v=0", i, bus.o_mutiplicado, bus.o_valid, last_res);
      end
    end
    drive(1'b0, 13'd0, 13'd0);
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic [12:0] a, b;
    a = 13'b0_1000_01010101;
    b = 13'b1_0111_11110000;
    drive(1'b1, a, b);
    @(posedge clock);
    #2;
    drive(1'b1, b, b);
    i_rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.o_mutiplicado !== 13'd0 || bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: got o=%b v=%b, want o=0 v=0", bus.o_mutiplicado, bus.o_valid);
    end
    @(negedge clock);
    drive(1'b0, a, b);
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests_run++;
      if (bus.o_mutiplicado !== 13'd0 || bus.o_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_release[%0d]: got o=%b v=%b, want o=0 v=0", i, bus.o_mutiplicado, bus.o_valid);
      end
    end
    drive(1'b1, a, b);
    @(negedge clock);
    drive(1'b0, 13'd0, 13'd0);
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_mutiplicado !== ref_mul(a, b)) begin
      tests_failed++;
      $display("FAIL reset_first: got o=%b v=%b, want o=%b v=1", bus.o_mutiplicado, bus.o_valid, ref_mul(a, b));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_res     = 13'd0;
    i_rst_n      = 1'b0;
    drive(1'b0, 13'd0, 13'd0);
    test_reset();
    test_plan();
    test_back_to_back();
    test_special();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/top_ej1_fmul.md
Name:
top_ej1_fmul

Overview:
- Registered multiplier for a custom 13-bit floating-point format: 1 sign bit, 4-bit exponent, 8-bit fraction, hidden leading 1, exponent bias 7.
- Value = (-1)^s × 1.f × 2^(e-7).
- Exponent field 0 encodes zero; there are no subnormals, infinities or NaNs.
- Sits as the top of the float-multiply exercise. A mantissa-multiplier sub-block feeds a normalise/pack stage, and the result is registered.

Parameters:
- EXP_W, 4, exponent field width.
- MAN_W, 8, fraction field width.
- BIAS, 7, exponent bias.

Ports:
- clock  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  operands valid this cycle.
- i_flotante_1  in  13  operand A, {s, e[3:0], f[7:0]}.
- i_flotante_2  in  13  operand B, same format.
- o_mutiplicado  out  13  product A×B, same format.
- o_valid  out  1  o_mutiplicado holds the result of an accepted operand pair.

Behaviour:
- Reset: while i_rst_n=0, o_mutiplicado=13'd0 and o_valid=0, asynchronously.
- Latency: exactly 1 cycle.
  - On the rising edge where i_valid=1, the product of that cycle's operands is registered and o_valid=1 from that edge.
  - An edge with i_valid=0 clears o_valid; o_mutiplicado holds its last value.
  - No backpressure. A new operand pair may be accepted every cycle.
- Sign: s_out = s1 XOR s2, in all cases including zero and saturation.
- Mantissa: 9×9 unsigned product P = {1,f1}×{1,f2}, 18 bits, with P in [2^16, 2^18).
- Normalise:
  - If P[17]=1: fraction = P[16:9], norm=1.
  - Else: fraction = P[15:8], norm=0.
  - Discarded bits are truncated toward zero.
- Exponent: E = e1 + e2 − BIAS + norm, computed in a signed width of at least 7 bits.
- Zero: if either e field is 0, the result is {s_out, 4'b0, 8'b0}.
- Underflow: if E ≤ 0, the result is {s_out, 0000, 00000000} (flush to zero).
- Overflow: if E ≥ 16, the result saturates to {s_out, 1111, 11111111}.
- Otherwise the result is {s_out, E[3:0], fraction}.
- Operation is commutative: swapping operands gives a bit-identical result.
- Reset asserted mid-operation discards the in-flight result. The first valid output after release comes 1 cycle after the next accepted i_valid.

Optional Feature:
- Macro FMUL_ROUND_NEAREST_EN.
- When defined, the fraction is rounded to nearest-even using the guard bit and sticky bit of the discarded product bits.
  - A mantissa carry-out renormalises: exponent +1, fraction becomes 0.
  - Overflow and underflow are checked after rounding.
- When undefined, truncation applies as in Behaviour, and the Test Plan values hold.

Decomposition:
- Package float13_pkg holds:
  - constants EXP_W, MAN_W, BIAS, EXP_MAX=15, FLT_W=13;
  - a packed struct typedef {sign, exp, frac};
  - the constants ZERO and SAT_MAG.
- One sub-module, fmul_mantissa: a combinational 9×9 multiplier plus normaliser producing fraction[7:0] and norm.
- The top holds sign, exponent arithmetic, special cases and the output register.

Test Plan:
- Basic product: 1_0101_11000110 (−0.443359375) × 0_1100_00011101 (35.625), i_valid=1 → next cycle o_mutiplicado=1_1010_11111001 (−15.78125), o_valid=1.
- Normalisation: 0_0011_11001101 × 1_1011_00101011 (−18.6875) → 1_1000_00001101 (−2.1015625).
- Norm with fraction truncated to 0: 0_1100_00011101 × 0_0011_11001101 → 0_1001_00000000 (4.0). Then 1_0101_11000110 × 1_1011_00101011 → 0_1010_00001001 (8.28125).
- Commutativity and back-to-back: repeat the three cases above with operands swapped on consecutive cycles → identical results, each 1 cycle later, with o_valid continuously 1.
- Special cases:
  - 13'd0 × 0_1100_00011101 → 0_0000_00000000.
  - 0_0001_00000000 × 0_0001_00000000 → 0_0000_00000000 (underflow).
  - 0_1111_00000000 × 1_1111_00000000 → 1_1111_11111111 (saturate).
- Reset: assert i_rst_n=0 mid-stream → o_mutiplicado=0 and o_valid=0 immediately, without waiting for a clock edge. After release with i_valid=0, o_valid stays 0.
